// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Brief    : Shared widths, reset PC, PC step and queue entry type for the
//            instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package if_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Control, instruction-memory and fetch-to-decode signal bundle.
//            Performance counter outputs exist only when IF_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
    import if_pkg::*;

    logic               stall;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;

    logic               imem_rd;
    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    logic               ifid_valid;
    logic [INSTR_W-1:0] ifid_instr;
    logic [XLEN-1:0]    ifid_pc;

`ifdef IF_PERF_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stall;
    logic [31:0]        perf_redirect;
`endif

    // Fetch stage side
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
`ifdef IF_PERF_EN
        output perf_fetched, perf_stall, perf_redirect,
`endif
        output imem_rd, imem_addr, ifid_valid, ifid_instr, ifid_pc
    );

    // Environment side: decode, execute and instruction memory
    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
`ifdef IF_PERF_EN
        input  perf_fetched, perf_stall, perf_redirect,
`endif
        input  imem_rd, imem_addr, ifid_valid, ifid_instr, ifid_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Two-entry {instr, pc} queue with push, pop, synchronous clear and
//            asynchronous reset; exposes occupancy and the head entry.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import if_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clear,
    input  wire logic         i_push,
    input  wire logic         i_pop,
    input  wire fetch_entry_t i_push_entry,
    output      logic [1:0]   o_count,
    output      fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop  & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is masked whenever the queue is empty
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;

    a_count_max: assert property (@(posedge clk) disable iff (rst) r_count <= 2'd2);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Program counter, memory issue and inflight/kill tracking feeding
//            a two-entry queue toward decode. IF_PERF_EN adds perf counters.
// Revision : 1.0
// ============================================================================
module fetch_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_issue_pc;
    logic            r_inflight;
    logic            r_kill;

    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [2:0]      w_occupancy;

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid & ~bus.stall;

    // Pop only happens with a non-empty queue, so the subtraction cannot wrap
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = ~rst & ~bus.redirect & (w_occupancy < 3'd2);

    assign w_push       = r_inflight & ~r_kill;
    assign w_push_entry = '{instr: bus.imem_rdata, pc: r_issue_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_issue_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (bus.redirect) begin
                r_pc   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                r_kill <= r_inflight;
            end else begin
                r_kill <= 1'b0;
                if (w_issue) begin
                    r_pc       <= r_pc + PC_STEP;
                    r_issue_pc <= r_pc;
                end
            end
        end
    end

    fetch_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (bus.redirect),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_push_entry (w_push_entry),
        .o_count      (w_count),
        .o_head       (w_head)
    );

    assign bus.imem_rd    = w_issue;
    assign bus.imem_addr  = r_pc;
    assign bus.ifid_valid = w_valid;
    assign bus.ifid_instr = w_head.instr;
    assign bus.ifid_pc    = w_head.pc;

`ifdef IF_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched  <= 32'd0;
            r_perf_stall    <= 32'd0;
            r_perf_redirect <= 32'd0;
        end else begin
            if (w_pop)                r_perf_fetched  <= r_perf_fetched + 32'd1;
            if (w_valid && bus.stall) r_perf_stall    <= r_perf_stall + 32'd1;
            if (bus.redirect)         r_perf_redirect <= r_perf_redirect + 32'd1;
        end
    end

    assign bus.perf_fetched  = r_perf_fetched;
    assign bus.perf_stall    = r_perf_stall;
    assign bus.perf_redirect = r_perf_redirect;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage with an ordered PC scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    logic clk;
    logic rst;

    fetch_stage_if ifc ();
    fetch_stage_if ifc2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (ifc2)
    );

    int          checks;
    int          errors;
    logic        sb_on;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: the word stored at each address equals the address
    always @(posedge clk) begin
        if (ifc.imem_rd)  ifc.imem_rdata  <= ifc.imem_addr;
        if (ifc2.imem_rd) ifc2.imem_rdata <= ifc2.imem_addr;
    end

    // Scoreboard: every instruction decode accepts must be the next expected PC
    always @(negedge clk) begin
        if (sb_on && !rst && ifc.ifid_valid && !ifc.stall && !ifc.redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc %h expected none", ifc.ifid_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (ifc.ifid_pc !== exp_pc || ifc.ifid_instr !== exp_pc) begin
                    errors++;
                    $display("FAIL sb_order: got pc %h instr %h expected %h",
                             ifc.ifid_pc, ifc.ifid_instr, exp_pc);
                end
            end
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.imem_rd !== 1'b0 || ifc.imem_addr !== 32'h0 || ifc.ifid_valid !== 1'b0 ||
            ifc.ifid_instr !== 32'h0 || ifc.ifid_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rd %b addr %h v %b i %h pc %h expected 0 0 0 0 0",
                     ifc.imem_rd, ifc.imem_addr, ifc.ifid_valid, ifc.ifid_instr, ifc.ifid_pc);
        end
        checks++;
        if (ifc2.imem_addr !== 32'hFFFF_FFF8 || ifc2.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr_wrap: got addr %h rd %b expected fffffff8 0",
                     ifc2.imem_addr, ifc2.imem_rd);
        end
    endtask

    task automatic test_stream_stall;
        @(posedge clk); #1;
        rst   = 1'b0;
        sb_on = 1'b1;
        for (int a = 0; a <= 32'h40; a += 4) exp_q.push_back(32'(a));
        @(negedge clk);
        checks++;
        if (ifc.imem_rd !== 1'b1 || ifc.imem_addr !== 32'h0 || ifc.ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_issue: got rd %b addr %h v %b expected 1 0 0",
                     ifc.imem_rd, ifc.imem_addr, ifc.ifid_valid);
        end
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1: got valid %b expected 0", ifc.ifid_valid);
        end
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.ifid_pc !== 32'h0) begin
            errors++;
            $display("FAIL latency_c2: got valid %b pc %h expected 1 0", ifc.ifid_valid, ifc.ifid_pc);
        end
        checks++;
        if (ifc2.ifid_pc !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_0: got %h expected fffffff8", ifc2.ifid_pc);
        end
        @(posedge clk); #1;
        ifc.stall = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc2.ifid_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_1: got %h expected fffffffc", ifc2.ifid_pc);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (ifc.ifid_valid !== 1'b1 || ifc.ifid_pc !== 32'h4 || ifc.imem_rd !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold %0d: got v %b pc %h rd %b expected 1 4 0",
                         i, ifc.ifid_valid, ifc.ifid_pc, ifc.imem_rd);
            end
            if (i == 1) begin
                checks++;
                if (ifc2.ifid_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_2: got %h expected 0", ifc2.ifid_pc);
                end
            end
        end
        @(posedge clk); #1;
        ifc.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ifc.ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_gap %0d: got valid %b expected 1", i, ifc.ifid_valid);
            end
        end
    endtask

    task automatic test_redirect;
        @(posedge clk); #1;
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_0103;
        exp_q.delete();
        for (int a = 32'h100; a <= 32'h120; a += 4) exp_q.push_back(32'(a));
        @(negedge clk);
        checks++;
        if (ifc.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_issue: got rd %b expected 0", ifc.imem_rd);
        end
        @(posedge clk); #1;
        ifc.redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b0 || ifc.imem_rd !== 1'b1 || ifc.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_n1: got v %b rd %b addr %h expected 0 1 100",
                     ifc.ifid_valid, ifc.imem_rd, ifc.imem_addr);
        end
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_n2: got valid %b expected 0", ifc.ifid_valid);
        end
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.ifid_pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_n3: got v %b pc %h expected 1 100", ifc.ifid_valid, ifc.ifid_pc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_redirect_stall;
        @(posedge clk); #1;
        ifc.stall = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL full_before_redir: got v %b rd %b expected 1 0", ifc.ifid_valid, ifc.imem_rd);
        end
        @(posedge clk); #1;
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_0200;
        exp_q.delete();
        for (int a = 32'h200; a <= 32'h220; a += 4) exp_q.push_back(32'(a));
        @(posedge clk); #1;
        ifc.redirect = 1'b0;
        ifc.stall    = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b0 || ifc.imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL redir_stall_n1: got v %b addr %h expected 0 200", ifc.ifid_valid, ifc.imem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.ifid_pc !== 32'h200) begin
            errors++;
            $display("FAIL redir_stall_n3: got v %b pc %h expected 1 200", ifc.ifid_valid, ifc.ifid_pc);
        end
    endtask

    task automatic test_back_to_back_redirect;
        @(posedge clk); #1;
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_0300;
        exp_q.delete();
        @(posedge clk); #1;
        ifc.redirect_pc = 32'h0000_0402;
        exp_q.delete();
        for (int a = 32'h400; a <= 32'h420; a += 4) exp_q.push_back(32'(a));
        @(posedge clk); #1;
        ifc.redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b0 || ifc.imem_rd !== 1'b1 || ifc.imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL b2b_n1: got v %b rd %b addr %h expected 0 1 400",
                     ifc.ifid_valid, ifc.imem_rd, ifc.imem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.ifid_pc !== 32'h400) begin
            errors++;
            $display("FAIL b2b_n3: got v %b pc %h expected 1 400", ifc.ifid_valid, ifc.ifid_pc);
        end
        repeat (2) @(negedge clk);
`ifdef IF_PERF_EN
        checks++;
        if (ifc.perf_redirect !== 32'd4) begin
            errors++;
            $display("FAIL perf_redirect: got %0d expected 4", ifc.perf_redirect);
        end
`endif
    endtask

    task automatic test_reset_mid_stall;
        @(posedge clk); #1;
        ifc.stall = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL full_before_rst: got v %b rd %b expected 1 0", ifc.ifid_valid, ifc.imem_rd);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.imem_rd !== 1'b0 || ifc.imem_addr !== 32'h0 || ifc.ifid_valid !== 1'b0 ||
            ifc.ifid_instr !== 32'h0 || ifc.ifid_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: got rd %b addr %h v %b i %h pc %h expected 0 0 0 0 0",
                     ifc.imem_rd, ifc.imem_addr, ifc.ifid_valid, ifc.ifid_instr, ifc.ifid_pc);
        end
`ifdef IF_PERF_EN
        checks++;
        if (ifc.perf_fetched !== 32'd0 || ifc.perf_stall !== 32'd0 || ifc.perf_redirect !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst: got %0d %0d %0d expected 0 0 0",
                     ifc.perf_fetched, ifc.perf_stall, ifc.perf_redirect);
        end
`endif
        ifc.stall = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.ifid_valid !== 1'b1 || ifc.ifid_pc !== 32'h0) begin
            errors++;
            $display("FAIL restart: got v %b pc %h expected 1 0", ifc.ifid_valid, ifc.ifid_pc);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        ifc.stall = 1'b1;
        sb_on     = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        sb_on            = 1'b0;
        rst              = 1'b1;
        ifc.stall        = 1'b0;
        ifc.redirect     = 1'b0;
        ifc.redirect_pc  = 32'h0;
        ifc.imem_rdata   = 32'h0;
        ifc2.stall       = 1'b0;
        ifc2.redirect    = 1'b0;
        ifc2.redirect_pc = 32'h0;
        ifc2.imem_rdata  = 32'h0;

        test_reset();
        test_stream_stall();
        test_redirect();
        test_redirect_stall();
        test_back_to_back_redirect();
        test_reset_mid_stall();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
